// File: rtl/scandbl_pkg.sv
// Shared types and defaults for the 15 kHz -> 31 kHz line doubler.
// One buffered pixel is {blank, r, g, b}.
package scandbl_pkg;

   localparam int ADDR_W_DEF     = 9;
   localparam int MIN_LINE_DEF   = 64;
   localparam int HS_OUT_LEN_DEF = 54;
   localparam int LINE_LEN_RST   = 448;

   typedef struct packed {
      logic       blank;
      logic [2:0] r;
      logic [2:0] g;
      logic [2:0] b;
   } pix_t;

   localparam pix_t BLANK_PIX = '{blank: 1'b1, r: 3'd0, g: 3'd0, b: 3'd0};

   function automatic pix_t dim_pix(input pix_t p);
      pix_t o;
      o       = p;
      o.r     = p.r >> 1;
      o.g     = p.g >> 1;
      o.b     = p.b >> 1;
      return o;
   endfunction

endpackage

// File: rtl/scandbl_linebuf.sv
// Two-bank ping-pong line buffer: write port on ce_in, registered read port on ce_out.
// Read data valid one read-enable after the address; the last address always reads blank.
module scandbl_linebuf
   import scandbl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk_sys,
   input  logic              nRESET,
   input  logic              wr_en_i,
   input  logic              wr_bank_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  pix_t              wr_dat_i,
   input  logic              rd_en_i,
   input  logic              rd_bank_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output pix_t              rd_dat_o
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   pix_t mem [2**(ADDR_W+1)];
   pix_t rd_dat_q;

   always_ff @(posedge clk_sys) begin
      if (wr_en_i) mem[{wr_bank_i, wr_addr_i}] <= wr_dat_i;
   end

   always_ff @(posedge clk_sys or negedge nRESET) begin
      if (!nRESET) begin
         rd_dat_q <= '0;
      end else if (rd_en_i) begin
         rd_dat_q <= (rd_addr_i == LAST_ADDR) ? BLANK_PIX : mem[{rd_bank_i, rd_addr_i}];
      end
   end

   assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/video_scandoubler.sv
// Line doubler: captures each input line, replays the previous one twice at 2x pixel rate.
// Outputs lag the read address by one ce_out tick; SCANDBL_SCANLINES_EN dims the second copy.
module video_scandoubler
   import scandbl_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int HS_OUT_LEN = HS_OUT_LEN_DEF,
   parameter int MIN_LINE   = MIN_LINE_DEF
) (
   input  logic       clk_sys,
   input  logic       nRESET,
   input  logic       ce_in,
   input  logic       ce_out,
   input  logic       scanlines,
   input  logic       HSync_in,
   input  logic       VSync_in,
   input  logic       HBlank_in,
   input  logic [2:0] R_in,
   input  logic [2:0] G_in,
   input  logic [2:0] B_in,
   output logic       HSync_out,
   output logic       VSync_out,
   output logic       HBlank_out,
   output logic [2:0] R_out,
   output logic [2:0] G_out,
   output logic [2:0] B_out
);

   localparam int                LW      = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] HC_MAX  = '1;
   localparam logic [LW-1:0]     LEN_RST = LW'(LINE_LEN_RST);
   localparam logic [LW-1:0]     MIN_LEN = LW'(MIN_LINE);
   localparam logic [LW-1:0]     HS_LEN  = LW'(HS_OUT_LEN);

   logic [ADDR_W-1:0] hc_in_q, hc_in_d;
   logic [LW-1:0]     line_len_q, line_len_d;
   logic [ADDR_W-1:0] oc_q, oc_d;
   logic              phase_q, phase_d;
   logic              wr_bank_q, wr_bank_d;
   logic              hs_prev_q, hs_prev_d;
   logic              hs_out_q, hs_out_d;
   logic              vs_out_q, vs_out_d;
   logic              hs_edge;
   logic [LW-1:0]     meas_len;
   pix_t              wr_pix, rd_pix, out_pix;

   assign hs_edge = ce_in & HSync_in & ~hs_prev_q;
   // The pixel on the edge tick still belongs to the closing line, so it counts.
   assign meas_len = {1'b0, hc_in_q} + 1'b1;
   assign wr_pix   = '{blank: HBlank_in, r: R_in, g: G_in, b: B_in};

   always_comb begin
      hc_in_d    = hc_in_q;
      line_len_d = line_len_q;
      wr_bank_d  = wr_bank_q;
      hs_prev_d  = hs_prev_q;
      oc_d       = oc_q;
      phase_d    = phase_q;
      hs_out_d   = hs_out_q;
      vs_out_d   = vs_out_q;
      if (ce_in) begin
         hs_prev_d = HSync_in;
         if (hs_edge) begin
            hc_in_d   = '0;
            wr_bank_d = ~wr_bank_q;
            if (meas_len >= MIN_LEN) line_len_d = meas_len;
         end else if (hc_in_q != HC_MAX) begin
            hc_in_d = hc_in_q + 1'b1;
         end
      end
      if (ce_out) begin
         hs_out_d = ({1'b0, oc_q} < HS_LEN);
         if (oc_q == '0) vs_out_d = VSync_in;
         if ({1'b0, oc_q} == line_len_q - 1'b1) begin
            oc_d    = '0;
            phase_d = ~phase_q;
         end else begin
            oc_d = oc_q + 1'b1;
         end
      end
      // A new input line restarts replay even if the counter was about to wrap.
      if (hs_edge) begin
         oc_d    = '0;
         phase_d = 1'b0;
      end
   end

   always_ff @(posedge clk_sys or negedge nRESET) begin
      if (!nRESET) begin
         hc_in_q    <= '0;
         line_len_q <= LEN_RST;
         wr_bank_q  <= 1'b0;
         hs_prev_q  <= 1'b0;
         oc_q       <= '0;
         phase_q    <= 1'b0;
         hs_out_q   <= 1'b0;
         vs_out_q   <= 1'b0;
      end else begin
         hc_in_q    <= hc_in_d;
         line_len_q <= line_len_d;
         wr_bank_q  <= wr_bank_d;
         hs_prev_q  <= hs_prev_d;
         oc_q       <= oc_d;
         phase_q    <= phase_d;
         hs_out_q   <= hs_out_d;
         vs_out_q   <= vs_out_d;
      end
   end

   scandbl_linebuf #(.ADDR_W(ADDR_W)) u_linebuf (
      .clk_sys   (clk_sys),
      .nRESET    (nRESET),
      .wr_en_i   (ce_in && (hc_in_q != HC_MAX)),
      .wr_bank_i (wr_bank_q),
      .wr_addr_i (hc_in_q),
      .wr_dat_i  (wr_pix),
      .rd_en_i   (ce_out),
      .rd_bank_i (~wr_bank_q),
      .rd_addr_i (oc_q),
      .rd_dat_o  (rd_pix)
   );

`ifdef SCANDBL_SCANLINES_EN
   logic dim_q;

   always_ff @(posedge clk_sys or negedge nRESET) begin
      if (!nRESET)     dim_q <= 1'b0;
      else if (ce_out) dim_q <= scanlines & phase_q;
   end

   assign out_pix = dim_q ? dim_pix(rd_pix) : rd_pix;
`else
   logic unused_scanlines;
   assign unused_scanlines = scanlines;
   assign out_pix          = rd_pix;
`endif

   assign HSync_out  = hs_out_q;
   assign VSync_out  = vs_out_q;
   assign HBlank_out = out_pix.blank;
   assign R_out      = out_pix.r;
   assign G_out      = out_pix.g;
   assign B_out      = out_pix.b;

endmodule

// File: tb/tb_video_scandoubler.sv
// Bench for video_scandoubler: randomized lines against a line-level reference model.
`timescale 1ns/1ps
module tb_video_scandoubler;
   import scandbl_pkg::*;

   logic       clk_sys = 1'b0, nRESET = 1'b0, ce_in = 1'b0, ce_out = 1'b0, scanlines = 1'b0;
   logic       HSync_in = 1'b0, VSync_in = 1'b0, HBlank_in = 1'b0;
   logic [2:0] R_in = 3'd0, G_in = 3'd0, B_in = 3'd0;
   logic       HSync_out, VSync_out, HBlank_out;
   logic [2:0] R_out, G_out, B_out;

   int compared   = 0;
   int mismatched = 0;
   int tcount     = 0;

   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) tcount <= tcount + 1;

   video_scandoubler dut (
      .clk_sys(clk_sys), .nRESET(nRESET), .ce_in(ce_in), .ce_out(ce_out), .scanlines(scanlines),
      .HSync_in(HSync_in), .VSync_in(VSync_in), .HBlank_in(HBlank_in),
      .R_in(R_in), .G_in(G_in), .B_in(B_in),
      .HSync_out(HSync_out), .VSync_out(VSync_out), .HBlank_out(HBlank_out),
      .R_out(R_out), .G_out(G_out), .B_out(B_out)
   );

   // Reference model: an output line is the previous captured input line replayed
   // every len_m output ticks, measured from the first output tick after the HSync edge.
   pix_t prev_line[$];
   pix_t cur_line[$];
   int   len_m     = 448;
   int   tick_m    = -1;
   bit   vs_m      = 1'b0;
   bit   hs_prev_m = 1'b0;

   typedef struct {
      int         t;
      logic [1:0] sa, se;
      logic [9:0] da, de;
      bit         dk;
   } rec_t;
   rec_t recs[$];

   task automatic model_reset();
      prev_line.delete();
      cur_line.delete();
      len_m     = 448;
      tick_m    = -1;
      vs_m      = 1'b0;
      hs_prev_m = 1'b0;
   endtask

   // One input pixel period: four clocks, ce_in on the first, ce_out on the first and third.
   task automatic step(input bit hs, input bit vs, input bit sl, input pix_t p);
      rec_t r;
      int   pos, cnt;
      bit   dim;
      pix_t e;
      for (int c = 0; c < 4; c++) begin
         ce_in     = (c == 0);
         ce_out    = (c % 2 == 0);
         HSync_in  = hs;
         VSync_in  = vs;
         scanlines = sl;
         {HBlank_in, R_in, G_in, B_in} = p;
         @(posedge clk_sys);
         if (ce_out) begin
            tick_m++;
            pos = tick_m % len_m;
            if (pos == 0) vs_m = vs;
            r.se = {pos < 54, vs_m};
            r.dk = 1'b0;
            r.de = '0;
            dim  = 1'b0;
`ifdef SCANDBL_SCANLINES_EN
            dim = sl && (((tick_m / len_m) % 2) == 1);
`endif
            if (pos >= 511) begin
               r.dk = 1'b1;
               r.de = 10'h200;
            end else if (pos < prev_line.size()) begin
               e = prev_line[pos];
               if (dim) begin
                  e.r = e.r / 2;
                  e.g = e.g / 2;
                  e.b = e.b / 2;
               end
               r.dk = 1'b1;
               r.de = e;
            end
         end
         if (ce_in) begin
            cur_line.push_back(p);
            if (hs && !hs_prev_m) begin
               cnt = cur_line.size();
               if (cnt >= 64) len_m = (cnt > 512) ? 512 : cnt;
               prev_line = cur_line;
               cur_line.delete();
               tick_m = -1;
            end
            hs_prev_m = hs;
         end
         #1;
         if (ce_out) begin
            r.t  = tcount;
            r.sa = {HSync_out, VSync_out};
            r.da = {HBlank_out, R_out, G_out, B_out};
            recs.push_back(r);
         end
      end
   endtask

   // mode 0: random pixels, 1: R = position[2:0], 2: R = 7
   task automatic drive_line(input int len, input int hs_at, input int hs_w, input int hs2_at,
                             input bit vs, input bit sl, input int mode);
      pix_t       p;
      logic [9:0] rv;
      bit         hs;
      for (int k = 0; k < len; k++) begin
         rv = 10'($urandom);
         p  = rv;
         if (mode == 1) p.r = k[2:0];
         if (mode == 2) p.r = 3'd7;
         hs = (k >= hs_at && k < hs_at + hs_w) || (hs2_at >= 0 && k >= hs2_at && k < hs2_at + 8);
         step(hs, vs, sl, p);
      end
   endtask

   task automatic test_reset();
      nRESET = 1'b0;
      #3;
      compared++;
      if ({HSync_out, VSync_out, HBlank_out, R_out, G_out, B_out} !== 12'h000) begin
         mismatched++;
         $display("FAIL reset_async got=%h want=000", {HSync_out, VSync_out, HBlank_out, R_out, G_out, B_out});
      end
      ce_in  = 1'b1;
      ce_out = 1'b1;
      repeat (3) @(posedge clk_sys);
      #1;
      compared++;
      if ({HSync_out, VSync_out, HBlank_out, R_out, G_out, B_out} !== 12'h000) begin
         mismatched++;
         $display("FAIL reset_held got=%h want=000", {HSync_out, VSync_out, HBlank_out, R_out, G_out, B_out});
      end
      ce_in  = 1'b0;
      ce_out = 1'b0;
      nRESET = 1'b1;
      model_reset();
   endtask

   task automatic test_zx48();
      for (int l = 0; l < 5; l++) drive_line(448, 336, 32, -1, 1'b0, 1'b0, 1);
      foreach (recs[i]) begin
         compared++;
         if (recs[i].sa !== recs[i].se) begin
            mismatched++;
            $display("FAIL zx48_sync t=%0d got=%b want=%b", recs[i].t, recs[i].sa, recs[i].se);
         end
         if (recs[i].dk) begin
            compared++;
            if (recs[i].da !== recs[i].de) begin
               mismatched++;
               $display("FAIL zx48_pixel t=%0d got=%h want=%h", recs[i].t, recs[i].da, recs[i].de);
            end
         end
      end
      recs.delete();
   endtask

   task automatic test_line_switch();
      for (int l = 0; l < 4; l++) drive_line(456, 344, 32, -1, 1'b0, 1'b0, 1);
      foreach (recs[i]) begin
         compared++;
         if (recs[i].sa !== recs[i].se) begin
            mismatched++;
            $display("FAIL switch456_sync t=%0d got=%b want=%b", recs[i].t, recs[i].sa, recs[i].se);
         end
         if (recs[i].dk) begin
            compared++;
            if (recs[i].da !== recs[i].de) begin
               mismatched++;
               $display("FAIL switch456_pixel t=%0d got=%h want=%h", recs[i].t, recs[i].da, recs[i].de);
            end
         end
      end
      recs.delete();
   endtask

   task automatic test_spurious();
      drive_line(448, 336, 32, -1, 1'b0, 1'b0, 0);
      drive_line(448, 336, 8, 356, 1'b0, 1'b0, 0);
      drive_line(448, 336, 32, -1, 1'b0, 1'b0, 0);
      drive_line(448, 336, 32, -1, 1'b0, 1'b0, 0);
      foreach (recs[i]) begin
         compared++;
         if (recs[i].sa !== recs[i].se) begin
            mismatched++;
            $display("FAIL spurious_sync t=%0d got=%b want=%b", recs[i].t, recs[i].sa, recs[i].se);
         end
         if (recs[i].dk) begin
            compared++;
            if (recs[i].da !== recs[i].de) begin
               mismatched++;
               $display("FAIL spurious_pixel t=%0d got=%h want=%h", recs[i].t, recs[i].da, recs[i].de);
            end
         end
      end
      recs.delete();
   endtask

   task automatic test_vsync();
      int vs_hi = 0;
      for (int l = 0; l < 6; l++) drive_line(448, 336, 32, -1, (l >= 1 && l < 5), 1'b0, 0);
      foreach (recs[i]) begin
         compared++;
         if (recs[i].se[0]) vs_hi++;
         if (recs[i].sa !== recs[i].se) begin
            mismatched++;
            $display("FAIL vsync_sync t=%0d got=%b want=%b", recs[i].t, recs[i].sa, recs[i].se);
         end
         if (recs[i].dk) begin
            compared++;
            if (recs[i].da !== recs[i].de) begin
               mismatched++;
               $display("FAIL vsync_pixel t=%0d got=%h want=%h", recs[i].t, recs[i].da, recs[i].de);
            end
         end
      end
      compared++;
      if (vs_hi != 8 * 448) begin
         mismatched++;
         $display("FAIL vsync_span got=%0d ticks want=%0d", vs_hi, 8 * 448);
      end
      recs.delete();
   endtask

   task automatic test_scanlines();
      drive_line(448, 336, 32, -1, 1'b0, 1'b1, 2);
      drive_line(448, 336, 32, -1, 1'b0, 1'b1, 2);
      drive_line(448, 336, 32, -1, 1'b0, 1'b0, 2);
      drive_line(448, 336, 32, -1, 1'b0, 1'b0, 2);
      foreach (recs[i]) begin
         compared++;
         if (recs[i].sa !== recs[i].se) begin
            mismatched++;
            $display("FAIL scanlines_sync t=%0d got=%b want=%b", recs[i].t, recs[i].sa, recs[i].se);
         end
         if (recs[i].dk) begin
            compared++;
            if (recs[i].da !== recs[i].de) begin
               mismatched++;
               $display("FAIL scanlines_pixel t=%0d got=%h want=%h", recs[i].t, recs[i].da, recs[i].de);
            end
         end
      end
      recs.delete();
   endtask

   task automatic test_long_line();
      int blank_seen = 0;
      drive_line(520, 336, 32, -1, 1'b0, 1'b0, 0);
      drive_line(520, 336, 32, -1, 1'b0, 1'b0, 0);
      drive_line(448, 336, 32, -1, 1'b0, 1'b0, 0);
      drive_line(448, 336, 32, -1, 1'b0, 1'b0, 0);
      foreach (recs[i]) begin
         compared++;
         if (recs[i].de == 10'h200 && recs[i].dk) blank_seen++;
         if (recs[i].sa !== recs[i].se) begin
            mismatched++;
            $display("FAIL longline_sync t=%0d got=%b want=%b", recs[i].t, recs[i].sa, recs[i].se);
         end
         if (recs[i].dk) begin
            compared++;
            if (recs[i].da !== recs[i].de) begin
               mismatched++;
               $display("FAIL longline_pixel t=%0d got=%h want=%h", recs[i].t, recs[i].da, recs[i].de);
            end
         end
      end
      compared++;
      if (blank_seen == 0) begin
         mismatched++;
         $display("FAIL longline_coverage got=%0d blank-address ticks want>0", blank_seen);
      end
      recs.delete();
   endtask

   task automatic test_back_to_back();
      for (int l = 0; l < 4; l++)
         drive_line($urandom_range(440, 470), $urandom_range(300, 380), 32, -1,
                    1'($urandom), 1'($urandom), 0);
      foreach (recs[i]) begin
         compared++;
         if (recs[i].sa !== recs[i].se) begin
            mismatched++;
            $display("FAIL random_sync t=%0d got=%b want=%b", recs[i].t, recs[i].sa, recs[i].se);
         end
         if (recs[i].dk) begin
            compared++;
            if (recs[i].da !== recs[i].de) begin
               mismatched++;
               $display("FAIL random_pixel t=%0d got=%h want=%h", recs[i].t, recs[i].da, recs[i].de);
            end
         end
      end
      recs.delete();
   endtask

   task automatic test_reset_midline();
      drive_line(200, 1000, 32, -1, 1'b1, 1'b0, 0);
      recs.delete();
      nRESET = 1'b0;
      #1;
      compared++;
      if ({HSync_out, VSync_out, HBlank_out, R_out, G_out, B_out} !== 12'h000) begin
         mismatched++;
         $display("FAIL reset_midline got=%h want=000", {HSync_out, VSync_out, HBlank_out, R_out, G_out, B_out});
      end
      model_reset();
      ce_in    = 1'b0;
      ce_out   = 1'b0;
      HSync_in = 1'b0;
      repeat (3) @(posedge clk_sys);
      #1;
      nRESET = 1'b1;
      for (int l = 0; l < 3; l++) drive_line(448, 336, 32, -1, 1'b0, 1'b0, 1);
      foreach (recs[i]) begin
         compared++;
         if (recs[i].sa !== recs[i].se) begin
            mismatched++;
            $display("FAIL after_reset_sync t=%0d got=%b want=%b", recs[i].t, recs[i].sa, recs[i].se);
         end
         if (recs[i].dk) begin
            compared++;
            if (recs[i].da !== recs[i].de) begin
               mismatched++;
               $display("FAIL after_reset_pixel t=%0d got=%h want=%h", recs[i].t, recs[i].da, recs[i].de);
            end
         end
      end
      recs.delete();
   endtask

   initial begin
      test_reset();
      test_zx48();
      test_line_switch();
      test_spurious();
      test_vsync();
      test_scanlines();
      test_long_line();
      test_back_to_back();
      test_reset_midline();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
